// File: rtl/ldm_stm_pkg.sv
// ldm_stm_pkg: shared definitions for the LDM/STM block-transfer sequencer.
//   state_t     - sequencer FSM encoding (IDLE, XFER, WB, DONE)
//   NUM_REGS    - size of the architectural register list (16)
//   WORD_STEP   - byte distance between consecutive transfer words (4)
//   popcount16  - number of set bits in a 16-bit register list
package ldm_stm_pkg;

   localparam int NUM_REGS  = 16;
   localparam int WORD_STEP = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [4:0] popcount16(input logic [NUM_REGS-1:0] m);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < NUM_REGS; i++) c = c + {4'd0, m[i]};
      return c;
   endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// lowest_set_bit: priority picker returning the lowest-numbered set bit.
//   mask  in  16 - pending register list
//   index out 4  - index of the lowest set bit (0 when mask is empty)
//   valid out 1  - mask has at least one bit set
module lowest_set_bit
   import ldm_stm_pkg::*;
(
   input  logic [NUM_REGS-1:0] mask,
   output logic [3:0]          index,
   output logic                valid
);

   always_comb begin
      index = 4'd0;
      valid = |mask;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (mask[i]) index = 4'(i);
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: sequences ARM-style LDM/STM block transfers.
//   clk, reset                 - clock, synchronous active-high reset
//   start + command inputs     - reg_list, load, up, pre, writeback,
//                                base_reg, base_data; latched on start in IDLE
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ready/mem_rdata - memory port,
//                                one word per mem_ready cycle
//   rd_select/rd_data          - register bank read port (store data)
//   wr_select/wr_en/wr_data    - register bank write port (loads, writeback)
//   busy, done                 - activity flag and one-cycle completion pulse
module ldm_stm_sequencer
   import ldm_stm_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       reg_list,
   input  logic              load,
   input  logic              up,
   input  logic              pre,
   input  logic              writeback,
   input  logic [3:0]        base_reg,
   input  logic [DATA_W-1:0] base_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [3:0]        rd_select,
   input  logic [DATA_W-1:0] rd_data,
   output logic [3:0]        wr_select,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_STEP);

   state_t              state, nxt;
   logic [15:0]         lst;        // registers still to transfer
   logic [DATA_W-1:0]   cur_addr;
   logic [3:0]          base_idx;
   logic                is_load;
   logic                do_wb;
   logic [DATA_W-1:0]   wb_val;

   // Command-time address arithmetic, evaluated on the incoming command.
   logic [4:0]          n;
   logic [DATA_W-1:0]   four_n;
   logic [DATA_W-1:0]   start_addr;

   assign n      = popcount16(reg_list);
   assign four_n = DATA_W'(n) << 2;

   always_comb begin
      case ({up, pre})
         2'b10:   start_addr = base_data;
         2'b11:   start_addr = base_data + STEP;
         2'b00:   start_addr = base_data - four_n + STEP;
         default: start_addr = base_data - four_n;
      endcase
   end

   logic [3:0]  cur;
   logic        cur_vld;
   logic [15:0] rest;
   logic        xfer_go;

   lowest_set_bit u_lsb (
      .mask  (lst),
      .index (cur),
      .valid (cur_vld)
   );

   assign rest    = lst & ~(16'h0001 << cur);
   assign xfer_go = (state == XFER) && cur_vld && mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         lst      <= '0;
         cur_addr <= '0;
         base_idx <= '0;
         is_load  <= 1'b0;
         do_wb    <= 1'b0;
         wb_val   <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            lst      <= reg_list;
            cur_addr <= start_addr;
            base_idx <= base_reg;
            is_load  <= load;
            // A load that includes the base keeps the loaded value.
            do_wb    <= writeback && !(load && reg_list[base_reg]);
            wb_val   <= up ? base_data + four_n : base_data - four_n;
         end else if (xfer_go) begin
            lst      <= rest;
            cur_addr <= cur_addr + STEP;
         end
      end
   end

   always_comb begin
      nxt       = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rd_select = 4'd0;
      wr_select = 4'd0;
      wr_en     = 1'b0;
      wr_data   = '0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state)
         IDLE: begin
            if (start) nxt = (reg_list == 16'h0000) ? DONE : XFER;
         end
         XFER: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_addr = cur_addr;
            mem_we   = !is_load;
            if (!is_load) begin
               rd_select = cur;
               mem_wdata = rd_data;
            end else if (mem_ready) begin
               wr_en     = 1'b1;
               wr_select = cur;
               wr_data   = mem_rdata;
            end
            if (xfer_go && rest == 16'h0000) nxt = do_wb ? WB : DONE;
         end
         WB: begin
            busy      = 1'b1;
            wr_en     = 1'b1;
            wr_select = base_idx;
            wr_data   = wb_val;
            nxt       = DONE;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase

      // Outputs are quiet for the whole reset cycle, not just after it.
      if (reset) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         rd_select = 4'd0;
         wr_select = 4'd0;
         wr_en     = 1'b0;
         wr_data   = '0;
         busy      = 1'b0;
         done      = 1'b0;
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, load, up, pre, writeback, mem_ready;
   logic [15:0] reg_list;
   logic [3:0]  base_reg, rd_select, wr_select;
   logic [31:0] base_data, mem_addr, mem_wdata, mem_rdata, rd_data, wr_data;
   logic        mem_req, mem_we, wr_en, busy, done;

   int tests = 0;
   int fails = 0;

   localparam logic [31:0] RMASK = 32'h5A5A_0000;

   // Memory returns a tag of its address; the register bank a tag of its index.
   assign mem_rdata = mem_addr ^ RMASK;
   assign rd_data   = 32'h1000_0000 | {28'd0, rd_select};

   always #5 clk = ~clk;

   ldm_stm_sequencer #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
      .load(load), .up(up), .pre(pre), .writeback(writeback),
      .base_reg(base_reg), .base_data(base_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .rd_select(rd_select), .rd_data(rd_data),
      .wr_select(wr_select), .wr_en(wr_en), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic [15:0]      list;
      logic             ld, u, p, w;
      logic [3:0]       breg;
      logic [31:0]      base;
      int               n;
      logic [31:0]      addr0;
      logic [3:0][3:0]  regs;
      int               exp_wb;
      logic [31:0]      wb_val;
      int               done_cyc;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_cmd(input vec_t v);
      reg_list  = v.list;
      load      = v.ld;
      up        = v.u;
      pre       = v.p;
      writeback = v.w;
      base_reg  = v.breg;
      base_data = v.base;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int k = 0;
      int wb_seen = 0;
      int c = 1;
      bit fin = 0;
      logic [31:0] ea;
      @(negedge clk);
      drive_cmd(v);
      start = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin && c <= 40) begin
         #1;
         if (mem_req) begin
            if (k < v.n) begin
               ea = v.addr0 + 32'(4 * k);
               chk($sformatf("v%0d addr%0d", id, k), mem_addr, ea);
               chk($sformatf("v%0d we%0d", id, k), {31'd0, mem_we}, {31'd0, !v.ld});
               if (v.ld) begin
                  chk($sformatf("v%0d wsel%0d", id, k), {28'd0, wr_select}, {28'd0, v.regs[k]});
                  chk($sformatf("v%0d wdat%0d", id, k), wr_data, ea ^ RMASK);
                  chk($sformatf("v%0d wen%0d", id, k), {31'd0, wr_en}, 32'd1);
               end else begin
                  chk($sformatf("v%0d rsel%0d", id, k), {28'd0, rd_select}, {28'd0, v.regs[k]});
                  chk($sformatf("v%0d sdat%0d", id, k), mem_wdata, 32'h1000_0000 | {28'd0, v.regs[k]});
               end
            end
            k++;
         end else if (wr_en) begin
            wb_seen++;
            chk($sformatf("v%0d wb_sel", id), {28'd0, wr_select}, {28'd0, v.breg});
            chk($sformatf("v%0d wb_val", id), wr_data, v.wb_val);
         end
         if (done) begin
            chk($sformatf("v%0d done_cyc", id), c, v.done_cyc);
            chk($sformatf("v%0d busy_done", id), {31'd0, busy}, 32'd1);
            fin = 1;
         end else begin
            @(negedge clk);
            c++;
         end
      end
      if (!fin) chk($sformatf("v%0d timeout", id), 32'd0, 32'd1);
      chk($sformatf("v%0d n_xfers", id), k, v.n);
      chk($sformatf("v%0d n_wb", id), wb_seen, v.exp_wb);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d idle_busy", id), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d idle_done", id), {31'd0, done}, 32'd0);
   endtask

   initial begin
      //            list     ld u  p  w  breg   base          n  addr0         regs      wb wb_val        done
      vecs[0] = '{16'h0005, 1, 1, 0, 1, 4'd13, 32'h0000_0100, 2, 32'h0000_0100, 16'h0020, 1, 32'h0000_0108, 4};
      vecs[1] = '{16'h8002, 0, 0, 1, 0, 4'd13, 32'h0000_0200, 2, 32'h0000_01F8, 16'h00F1, 0, 32'h0,         3};
      vecs[2] = '{16'h0018, 1, 1, 1, 1, 4'd3,  32'h0000_0300, 2, 32'h0000_0304, 16'h0043, 0, 32'h0,         3};
      vecs[3] = '{16'h00F0, 0, 0, 0, 1, 4'd13, 32'h0000_1000, 4, 32'h0000_0FF4, 16'h7654, 1, 32'h0000_0FF0, 6};
      vecs[4] = '{16'h0000, 1, 1, 0, 1, 4'd13, 32'h0000_0100, 0, 32'h0,         16'h0000, 0, 32'h0,         1};
      vecs[5] = '{16'h0001, 0, 1, 1, 1, 4'd13, 32'hFFFF_FFFC, 1, 32'h0000_0000, 16'h0000, 1, 32'h0000_0000, 3};
      vecs[6] = '{16'h0008, 0, 1, 0, 1, 4'd3,  32'h0000_0040, 1, 32'h0000_0040, 16'h0003, 1, 32'h0000_0044, 3};

      reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
      drive_cmd(vecs[0]);
      repeat (2) @(negedge clk);
      #1;
      chk("rst mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst addr", mem_addr, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Stalled second transfer; a start pulse during the stall must be ignored.
      @(negedge clk);
      drive_cmd(vecs[0]);
      writeback = 1'b0;
      start = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("stall a0", mem_addr, 32'h100);
      chk("stall wen0", {31'd0, wr_en}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         start = (i == 1);
         reg_list = 16'hFFFF;
         #1;
         chk("stall req", {31'd0, mem_req}, 32'd1);
         chk("stall addr", mem_addr, 32'h104);
         chk("stall wen", {31'd0, wr_en}, 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("stall wen1", {31'd0, wr_en}, 32'd1);
      chk("stall wsel1", {28'd0, wr_select}, 32'd2);
      chk("stall wdat1", wr_data, 32'h104 ^ RMASK);
      @(negedge clk);
      #1;
      chk("stall done", {31'd0, done}, 32'd1);
      @(negedge clk);
      #1;
      chk("stall idle", {31'd0, busy}, 32'd0);

      // Reset in the middle of a long store burst.
      @(negedge clk);
      drive_cmd(vecs[3]);
      reg_list = 16'h00FF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid rst req", {31'd0, mem_req}, 32'd0);
      chk("mid rst busy", {31'd0, busy}, 32'd0);
      chk("mid rst addr", mem_addr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post rst req", {31'd0, mem_req}, 32'd0);
      chk("post rst busy", {31'd0, busy}, 32'd0);
      chk("post rst we", {31'd0, mem_we}, 32'd0);
      run_vec(vecs[0], 7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
